// File: rtl/mic_xcorr_lag.sv
// Time-delay estimator for one microphone pair: captures a window of sample pairs,
// then searches -MAX_LAG..+MAX_LAG for the lag with the largest cross-correlation.
module mic_xcorr_lag #(
   parameter int WINDOW  = 256,
   parameter int MAX_LAG = 16,
   parameter int ACC_W   = 32 + $clog2(WINDOW),
   parameter int LAG_W   = $clog2(MAX_LAG) + 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             enable_in,
   input  logic             a_valid_in,
   input  logic [15:0]      a_sample_in,
   input  logic             b_valid_in,
   input  logic [15:0]      b_sample_in,
   output logic             busy_out,
   output logic             result_valid_out,
   output logic [LAG_W-1:0] lag_out,
   output logic [ACC_W-1:0] peak_out,
   output logic [1:0]       state_dbg_out
);

   localparam int IDX_W = $clog2(WINDOW);
   localparam logic [IDX_W-1:0] N_FIRST  = IDX_W'(MAX_LAG);
   localparam logic [IDX_W-1:0] N_LAST   = IDX_W'(WINDOW - MAX_LAG - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW - 1);
   localparam logic signed [LAG_W-1:0] LAG_MIN = LAG_W'(-MAX_LAG);
   localparam logic signed [LAG_W-1:0] LAG_MAX = LAG_W'(MAX_LAG);

   typedef enum logic [1:0] {ST_CAPTURE = 2'd0, ST_COMPUTE = 2'd1, ST_REPORT = 2'd2} state_t;
   state_t state_q, state_d;

   // Strobes are single-cycle valids with no back-pressure: a strobe is consumed in the
   // cycle it is high, and only while capturing with enable_in high.
   logic [15:0]      a_hold_q, b_hold_q;
   logic             a_full_q, b_full_q;
   logic [IDX_W-1:0] wr_idx_q;
   logic [15:0]      a_pair, b_pair;
   logic             pair_wr, window_done;

   always_comb begin
      a_pair      = a_valid_in ? a_sample_in : a_hold_q;
      b_pair      = b_valid_in ? b_sample_in : b_hold_q;
      pair_wr     = (state_q == ST_CAPTURE) && enable_in &&
                    (a_valid_in || a_full_q) && (b_valid_in || b_full_q);
      window_done = pair_wr && (wr_idx_q == IDX_LAST);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         a_hold_q <= '0;
         b_hold_q <= '0;
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         wr_idx_q <= '0;
      end else if (state_q != ST_CAPTURE || !enable_in) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         wr_idx_q <= '0;
      end else if (pair_wr) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         wr_idx_q <= wr_idx_q + IDX_W'(1);
      end else begin
         if (a_valid_in) begin
            a_hold_q <= a_sample_in;
            a_full_q <= 1'b1;
         end
         if (b_valid_in) begin
            b_hold_q <= b_sample_in;
            b_full_q <= 1'b1;
         end
      end
   end

   // Issue stage: walks n over the fixed inner range once per lag, back to back.
   logic signed [LAG_W-1:0] lag_cnt_q;
   logic [IDX_W-1:0]        n_q;
   logic                    issue_q, issue_now;
   logic signed [IDX_W:0]   lag_ext;
   logic [IDX_W-1:0]        rd_addr_b;

   always_comb begin
      issue_now = (state_q == ST_COMPUTE) && issue_q;
      lag_ext   = (IDX_W+1)'(lag_cnt_q);
      rd_addr_b = IDX_W'($signed({1'b0, n_q}) + lag_ext);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         lag_cnt_q <= LAG_MIN;
         n_q       <= N_FIRST;
         issue_q   <= 1'b1;
      end else if (state_q != ST_COMPUTE) begin
         lag_cnt_q <= LAG_MIN;
         n_q       <= N_FIRST;
         issue_q   <= 1'b1;
      end else if (issue_q) begin
         if (n_q == N_LAST) begin
            n_q <= N_FIRST;
            if (lag_cnt_q == LAG_MAX) issue_q   <= 1'b0;
            else                      lag_cnt_q <= lag_cnt_q + LAG_W'(1);
         end else begin
            n_q <= n_q + IDX_W'(1);
         end
      end
   end

   logic [15:0]        mem_a [WINDOW];
   logic [15:0]        mem_b [WINDOW];
   logic signed [15:0] rd_a_q, rd_b_q;

   always_ff @(posedge clk_in) begin
      if (pair_wr) begin
         mem_a[wr_idx_q] <= a_pair;
         mem_b[wr_idx_q] <= b_pair;
      end
      rd_a_q <= mem_a[n_q];
      rd_b_q <= mem_b[rd_addr_b];
   end

   // Tags travel alongside the read and multiply stages so the accumulator knows lag boundaries.
   logic                    v1_q, first1_q, last1_q, v2_q, first2_q, last2_q;
   logic signed [LAG_W-1:0] lag1_q, lag2_q;
   logic signed [31:0]      prod_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         v1_q <= 1'b0; first1_q <= 1'b0; last1_q <= 1'b0; lag1_q <= '0;
         v2_q <= 1'b0; first2_q <= 1'b0; last2_q <= 1'b0; lag2_q <= '0;
         prod_q <= '0;
      end else begin
         v1_q     <= issue_now;
         first1_q <= (n_q == N_FIRST);
         last1_q  <= (n_q == N_LAST);
         lag1_q   <= lag_cnt_q;
         v2_q     <= v1_q;
         first2_q <= first1_q;
         last2_q  <= last1_q;
         lag2_q   <= lag1_q;
         prod_q   <= 32'(rd_a_q) * 32'(rd_b_q);
      end
   end

   logic signed [ACC_W-1:0] acc_q, best_val_q, sum_d, best_val_d;
   logic signed [LAG_W-1:0] best_lag_q, best_lag_d;
   logic                    take, done;
   logic [LAG_W-1:0]        lag_q;
   logic [ACC_W-1:0]        peak_q;

   always_comb begin
      sum_d      = first2_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
      take       = v2_q && last2_q && ((lag2_q == LAG_MIN) || (sum_d > best_val_q));
      best_val_d = take ? sum_d : best_val_q;
      best_lag_d = take ? lag2_q : best_lag_q;
      done       = v2_q && last2_q && (lag2_q == LAG_MAX);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         acc_q      <= '0;
         best_val_q <= '0;
         best_lag_q <= '0;
         lag_q      <= '0;
         peak_q     <= '0;
      end else begin
         if (v2_q) acc_q <= sum_d;
         best_val_q <= best_val_d;
         best_lag_q <= best_lag_d;
         if (done) begin
            lag_q  <= best_lag_d;
            peak_q <= best_val_d;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= ST_CAPTURE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CAPTURE: if (window_done) state_d = ST_COMPUTE;
         ST_COMPUTE: if (done) state_d = ST_REPORT;
         ST_REPORT:  state_d = ST_CAPTURE;
         default:    state_d = ST_CAPTURE;
      endcase
   end

   always_comb begin
      busy_out         = (state_q == ST_COMPUTE);
      result_valid_out = (state_q == ST_REPORT);
      lag_out          = lag_q;
      peak_out         = peak_q;
      state_dbg_out    = state_q;
   end

endmodule

// File: tb/tb_mic_xcorr_lag.sv
// Randomized bench for mic_xcorr_lag: windows are scored against a direct correlation
// search over the captured arrays.
module tb_mic_xcorr_lag;

   localparam int W        = 256;
   localparam int M        = 16;
   localparam int ACC_W    = 32 + $clog2(W);
   localparam int LAG_W    = $clog2(M) + 2;
   localparam int BUSY_MAX = (2*M+1)*(W-2*M+4)+8;
   localparam int DBL      = 50;

   logic             clk, rst_n, enable;
   logic             a_valid, b_valid;
   logic [15:0]      a_s, b_s;
   logic             busy, res_valid;
   logic [LAG_W-1:0] lag;
   logic [ACC_W-1:0] peak;
   logic [1:0]       state_dbg;

   mic_xcorr_lag #(.WINDOW(W), .MAX_LAG(M), .ACC_W(ACC_W), .LAG_W(LAG_W)) dut (
      .clk_in(clk), .rst_in(rst_n), .enable_in(enable),
      .a_valid_in(a_valid), .a_sample_in(a_s),
      .b_valid_in(b_valid), .b_sample_in(b_s),
      .busy_out(busy), .result_valid_out(res_valid),
      .lag_out(lag), .peak_out(peak), .state_dbg_out(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int a_arr [W];
   int b_arr [W];
   int x     [W+2*M];
   logic [LAG_W+ACC_W-1:0] exp_q [$];
   int n_vec = 0, n_err = 0, n_results = 0, busy_cnt = 0;

   task automatic check(input string name, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got no/extra event, expected otherwise at %0t", name, $time);
   endtask

   function automatic int rnd();
      return int'($urandom_range(0, 2000)) - 1000;
   endfunction

   // Reference: plain correlation sums over the fixed inner range, first strict maximum wins.
   task automatic model_push();
      longint best = 0;
      int best_l = -M;
      logic [LAG_W-1:0] el;
      logic [ACC_W-1:0] ep;
      for (int l = -M; l <= M; l++) begin
         longint r = 0;
         for (int n = M; n < W-M; n++) r += longint'(a_arr[n]) * longint'(b_arr[n+l]);
         if (l == -M || r > best) begin
            best = r;
            best_l = l;
         end
      end
      el = LAG_W'(best_l);
      ep = ACC_W'(best);
      exp_q.push_back({el, ep});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_a(input int v);
      a_valid = 1'b1; a_s = 16'(v);
      tick();
      a_valid = 1'b0;
   endtask

   task automatic strobe_b(input int v);
      b_valid = 1'b1; b_s = 16'(v);
      tick();
      b_valid = 1'b0;
   endtask

   task automatic pair_same(input int a, input int b);
      a_valid = 1'b1; b_valid = 1'b1; a_s = 16'(a); b_s = 16'(b);
      tick();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_window();
      for (int n = 0; n < W; n++) pair_same(a_arr[n], b_arr[n]);
   endtask

   task automatic wait_result();
      int start = n_results;
      int cyc = 0;
      while (n_results == start && cyc < 10000) begin
         tick();
         cyc++;
      end
      if (n_results == start) fail("result_timeout");
   endtask

   task automatic fill_shift(input int shift, input int sgn);
      for (int i = 0; i < W+2*M; i++) x[i] = rnd();
      for (int n = 0; n < W; n++) begin
         a_arr[n] = x[n+M];
         b_arr[n] = sgn * x[n+M+shift];
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (res_valid) begin
            n_results++;
            check("busy_low_at_report", busy, 0);
            check("busy_cycles_within_bound", busy_cnt <= BUSY_MAX, 1);
            busy_cnt = 0;
            if (exp_q.size() == 0) begin
               fail("unexpected_result");
            end else begin
               logic [LAG_W+ACC_W-1:0] e;
               logic [LAG_W-1:0] el;
               logic [ACC_W-1:0] ep;
               e = exp_q.pop_front();
               el = e[LAG_W+ACC_W-1:ACC_W];
               ep = e[ACC_W-1:0];
               check("lag", $signed(lag), $signed(el));
               check("peak", $signed(peak), $signed(ep));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; a_s = '0; b_s = '0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_lag", $signed(lag), 0);
      check("rst_peak", $signed(peak), 0);
      rst_n = 1'b1;
      tick();

      // identical channels
      fill_shift(0, 1);
      model_push(); send_window(); wait_result();
      // B delayed by 5, then B advanced by 7
      fill_shift(-5, 1);
      model_push(); send_window(); wait_result();
      fill_shift(7, 1);
      model_push(); send_window(); wait_result();
      // inverted channel
      fill_shift(0, -1);
      model_push(); send_window(); wait_result();
      // all zeros: every sum ties, most negative lag kept
      for (int n = 0; n < W; n++) begin a_arr[n] = 0; b_arr[n] = 0; end
      model_push(); send_window();
      repeat (3) tick();
      check("busy_in_compute", busy, 1);
      for (int i = 0; i < 60; i++) begin
         a_valid = 1'($urandom_range(0, 1)); a_s = 16'(rnd());
         b_valid = 1'($urandom_range(0, 1)); b_s = 16'(rnd());
         tick();
      end
      a_valid = 1'b0; b_valid = 1'b0;
      wait_result();

      // partial window then enable low: the partial data must be discarded
      for (int n = 0; n < 100; n++) pair_same(rnd(), rnd());
      enable = 1'b0;
      for (int n = 0; n < 20; n++) pair_same(rnd(), rnd());
      check("busy_while_disabled", busy, 0);
      enable = 1'b1;
      tick();

      // A leads B by 3 cycles per pair, with one double A strobe
      fill_shift(-3, 1);
      a_arr[DBL] = 200;
      model_push();
      for (int n = 0; n < W-1; n++) begin
         if (n == DBL) begin
            strobe_a(100); tick(); strobe_a(200);
         end else begin
            strobe_a(a_arr[n]);
         end
         tick(); tick();
         strobe_b(b_arr[n]);
      end
      strobe_a(a_arr[W-1]); tick(); tick();
      b_valid = 1'b1; b_s = 16'(b_arr[W-1]);
      check("busy_before_last_pair", busy, 0);
      tick();
      b_valid = 1'b0;
      check("busy_after_last_pair", busy, 1);
      wait_result();

      // reset in the middle of a computation
      fill_shift(2, 1);
      model_push(); send_window();
      repeat (2000) tick();
      check("busy_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", res_valid, 0);
      check("midrst_lag", $signed(lag), 0);
      check("midrst_peak", $signed(peak), 0);
      exp_q.delete();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      fill_shift(-4, -1);
      model_push(); send_window(); wait_result();

      repeat (5) tick();
      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mic_xcorr_lag.md
# mic_xcorr_lag

Cross-correlation time-delay estimator for one microphone pair. It consumes the per-mic 16-bit sample strobes produced by the I2S receivers, or the anti-aliased and decimated streams, and captures a fixed-length window of sample pairs. It then computes the integer lag that maximises the correlation between the two channels and reports that lag and its correlation peak. Downstream direction-finding logic and the seven-segment debug display use the result.

## Interface
Parameters:
- WINDOW, 256: sample pairs per capture window; must be a power of two and greater than 4*MAX_LAG.
- MAX_LAG, 16: search range is -MAX_LAG..+MAX_LAG samples inclusive.
- ACC_W, 32+$clog2(WINDOW): accumulator width.
- LAG_W, $clog2(MAX_LAG)+2: signed lag output width.

Ports:
- clk_in  input  1  single clock for all logic (audio_clk, 98.3 MHz).
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  level; when low, capture halts and any partial window is discarded.
- a_valid_in  input  1  single-cycle strobe; a_sample_in is valid.
- a_sample_in  input  16  signed sample, channel A.
- b_valid_in  input  1  single-cycle strobe; b_sample_in is valid.
- b_sample_in  input  16  signed sample, channel B.
- busy_out  output  1  high during COMPUTE.
- result_valid_out  output  1  one-cycle pulse when lag_out and peak_out update.
- lag_out  output  LAG_W  signed best lag; positive means channel B lags channel A.
- peak_out  output  ACC_W  signed correlation sum at lag_out.

## Operation
- States are CAPTURE, COMPUTE, and REPORT. Reset enters CAPTURE with write index 0.
- Pairing: each channel has a holding register and a full flag.
  - A strobe loads the register and sets the flag. A second strobe on the same channel before a pair forms overwrites the register (newest sample wins).
  - When both flags are set, the pair is written to buffers A and B at the write index, both flags clear, and the index increments.
  - Strobes on both channels in the same cycle form a pair directly.
- CAPTURE transitions to COMPUTE when the pair at index WINDOW-1 is written.
- COMPUTE loops L from -MAX_LAG to +MAX_LAG.
  - For each L: r(L) = sum of a[n]*b[n+L] for n = MAX_LAG .. WINDOW-MAX_LAG-1. Every lag uses the same WINDOW-2*MAX_LAG terms.
  - Products are full 32-bit signed. Accumulation is signed, ACC_W wide, with no saturation; ACC_W guarantees no overflow.
  - Argmax: r(-MAX_LAG) initialises the best value. A later lag replaces it only if strictly greater, so ties keep the most negative lag.
- After the last lag retires from the pipeline, the FSM goes to REPORT. REPORT registers lag_out and peak_out, pulses result_valid_out for 1 cycle, clears the write index and pair flags, and returns to CAPTURE.
- Strobes arriving during COMPUTE and REPORT are ignored. Each window is contiguous new data captured after the previous result.
- enable_in low:
  - In CAPTURE, it clears the index and flags and ignores strobes.
  - In COMPUTE, the computation finishes and reports normally; capture then waits for enable_in.
- Buffers are 2 x WINDOW x 16-bit synchronous-read RAM, intended to infer BRAM. The datapath runs at 1 multiply-accumulate per cycle, pipelined as read, multiply, accumulate.

## Timing
- Reset values: busy_out 0, result_valid_out 0, lag_out 0, peak_out 0, state CAPTURE, index 0, flags 0. Reset is effective mid-operation; no partial result is emitted.
- busy_out rises the cycle after the WINDOW-th pair is written and falls in the same cycle result_valid_out pulses.
- COMPUTE latency is at most (2*MAX_LAG+1)*(WINDOW-2*MAX_LAG+4)+8 cycles from the window-completing pair to result_valid_out. With default parameters this is 7532 cycles, about 77 us, much shorter than one 24 kHz sample period × WINDOW.
- lag_out and peak_out hold their values until the next REPORT.
- The earliest sample that can be captured is in the cycle after result_valid_out.

## Test plan
- A = B = the same ±1000 pseudo-random sequence, 256 pairs → lag_out 0, peak_out equal to the sum of a[n]² over n = 16..239, busy_out high for ≤ 7532 cycles.
- B is A delayed by 5 samples (b[n] = a[n-5]) → lag_out +5. B is A advanced by 7 samples → lag_out -7.
- B = -A → lag_out is the lag of the maximum of the negated autocorrelation. Also drive A = B = all zeros → all r(L) = 0, so lag_out = -16 and peak_out = 0 (tie rule).
- A strobes 3 cycles before B for every pair, then drive a double A strobe (values 100, then 200) before one B strobe → the pair uses 200, and exactly 256 pairs complete the window.
- Strobes during COMPUTE → ignored, so the second window's result matches the data sent after result_valid_out. Drop enable_in at pair 100 → the index resets, and no result appears until 256 fresh pairs have been captured.
- Assert rst_in low mid-COMPUTE → all outputs return to 0 immediately, with no result_valid_out pulse. A full window after reset gives the correct lag.
